axi_lite_regbank: RTL and testbench
===================================

Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank, the next generation of axi_lite_slave. Generalised in data width, register count and per-register access mode (RW / RO).
- Adds byte-strobe writes, independent AW/W acceptance, SLVERR decoding and per-register write pulses.
- Sits between the PS AXI-Lite master port and dataplane control/status logic.

Parameters:
DATA_W, 32, data bus width in bits; 32 or 64.
ADDR_W, 12, byte-address width.
NUM_REGS, 16, number of registers; 1..2**(ADDR_W-log2(DATA_W/8)).
RO_MASK, '0, NUM_REGS-bit mask; bit i=1 makes reg i read-only (reads sts_in slice i).
RST_VAL, '0, NUM_REGS*DATA_W reset image for RW registers.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
AWADDR  in  ADDR_W  write address
AWPROT  in  3  ignored
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  write response
ARADDR  in  ADDR_W  read address
ARPROT  in  3  ignored
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RDATA  out  DATA_W  read data
RRESP  out  2  read response
ctrl_out  out  NUM_REGS*DATA_W  RW register contents, reg i at [i*DATA_W +: DATA_W]
sts_in  in  NUM_REGS*DATA_W  status values for RO registers
wr_pulse  out  NUM_REGS  one-cycle strobe per successful write

Behaviour:
- Reset: one clock and one reset (clk, rst_n). rst_n is synchronous and active-low.
  - While rst_n=0 at a clk edge: all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, wr_pulse 0, RW regs loaded from RST_VAL.
  - Reset mid-transaction drops the transaction; no response is issued.
- Address decode: index = ADDR[ADDR_W-1:log2(DATA_W/8)]. Low byte-offset bits are ignored.
- Write channel: AW and W captured independently into holding registers.
  - AWREADY=1 when the AW holder is empty; WREADY=1 when the W holder is empty.
  - Simultaneous AW+W in one cycle is allowed; either order is accepted.
- Write commit: in the cycle both holders are full and BVALID=0:
  - index<NUM_REGS and RO_MASK[index]=0: reg bytes with WSTRB=1 updated, other bytes kept; wr_pulse[index]=1 next cycle for exactly one cycle; BRESP=OKAY (00).
  - index>=NUM_REGS or RO_MASK[index]=1: no update, no pulse, BRESP=SLVERR (10).
  - WSTRB=0 to a valid RW reg: OKAY, no data change, wr_pulse still asserted.
- BVALID rises the cycle after commit and is held with BRESP stable until BREADY. Holders are freed at commit, so a new AW/W can be accepted while BVALID is pending. Max one response outstanding; the next commit waits for the B handshake.
- Read: ARREADY=1 when RVALID=0 or (RVALID & RREADY), giving back-to-back reads at one per cycle.
  - RDATA/RRESP are registered; RVALID rises the cycle after the AR handshake (latency 1) and is held stable until RREADY.
  - RW reg → stored value; RO reg → sts_in sampled at the AR handshake cycle; OKAY.
  - Out-of-range → RDATA=0, SLVERR.
- Read/write same register in the same cycle: the read returns the pre-write value.
- ctrl_out updates the cycle after commit, aligned with wr_pulse.

Decomposition:
- Package axi_lite_pkg:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - typedef resp_t.
  - Function clog2-based index extraction helper.
- One sub-module, axi_lite_wr_hold: a single-entry holding register with valid/ready. Instantiated twice (AW and W).
- The read path and register array are inline.

Test Plan:
1. Reset with DATA_W=32, NUM_REGS=4, RST_VAL reg1=0xDEADBEEF → read 0x004 gives 0xDEADBEEF, OKAY, RVALID 1 cycle after AR handshake.
2. AW 0x008 three cycles before W 0x12345678 STRB 4'hF → BVALID OKAY; wr_pulse[2] high for 1 cycle; readback 0x12345678.
3. Reg2=0x12345678, write 0xAABBCCDD STRB 4'b0101 → readback 0x12BB56DD.
4. Write to 0x010 (index 4) → SLVERR, no wr_pulse. Read 0x010 → RDATA 0, SLVERR.
5. RO_MASK=4'b1000, sts_in reg3=0xCAFE0001 → write 0x00C gives SLVERR, value unchanged; read gives 0xCAFE0001.
6. BREADY held low 5 cycles → BVALID/BRESP stable, second AW/W accepted but not committed until B handshake. Back-to-back reads with RREADY=1 → one RVALID per cycle. rst_n low mid-write → all outputs 0, no B response.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared response codes and address-decode helper for the AXI4-Lite register bank.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] resp_t;

    // Register index of a byte address: the byte-offset bits inside one data
    // word are dropped, so any address within a word selects that word.
    function automatic logic [31:0] reg_index(input logic [63:0] addr, input int unsigned data_w);
        return 32'(addr >> $clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_lite_wr_hold.sv
// Single-entry holding register: accepts one beat when empty, keeps it until released.
module axi_lite_wr_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_release,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    // Capture a beat while empty; the consumer empties the slot with i_release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_release) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_ready = ~r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite register bank with RW/RO registers, byte strobes,
// independent AW/W capture, SLVERR decode and per-register write pulses.
//
// Handshake rule on every channel: a beat transfers on the rising clk edge
// where VALID and READY are both 1. A source holds VALID and its payload
// stable until that edge; READY may rise or fall freely while VALID is low.
module axi_lite_regbank
    import axi_lite_pkg::*;
#(
    parameter int                          DATA_W   = 32,
    parameter int                          ADDR_W   = 12,
    parameter int                          NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0]         RO_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]  RST_VAL  = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             AWADDR,
    input  logic [2:0]                    AWPROT,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [DATA_W-1:0]             WDATA,
    input  logic [DATA_W/8-1:0]           WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic                          BVALID,
    input  logic                          BREADY,
    output logic [1:0]                    BRESP,
    input  logic [ADDR_W-1:0]             ARADDR,
    input  logic [2:0]                    ARPROT,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [DATA_W-1:0]             RDATA,
    output logic [1:0]                    RRESP,
    output logic [NUM_REGS*DATA_W-1:0]    ctrl_out,
    input  logic [NUM_REGS*DATA_W-1:0]    sts_in,
    output logic [NUM_REGS-1:0]           wr_pulse
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0]        r_regs [NUM_REGS];
    logic                     r_out_en;
    logic                     r_bvalid;
    resp_t                    r_bresp;
    logic [NUM_REGS-1:0]      r_wr_pulse;
    logic                     r_rvalid;
    resp_t                    r_rresp;
    logic [DATA_W-1:0]        r_rdata;

    logic                     w_aw_ready;
    logic                     w_aw_full;
    logic [ADDR_W-1:0]        w_aw_addr;
    logic                     w_w_ready;
    logic                     w_w_full;
    logic [DATA_W+STRB_W-1:0] w_w_hold;
    logic [DATA_W-1:0]        w_w_data;
    logic [STRB_W-1:0]        w_w_strb;
    logic                     w_commit;
    logic [31:0]              w_aw_index;
    logic [NUM_REGS-1:0]      w_wr_sel;
    logic                     w_arready;
    logic                     w_ar_hs;
    logic [31:0]              w_ar_index;
    logic [DATA_W-1:0]        w_rd_data;
    resp_t                    w_rd_resp;
    logic                     w_unused;

    assign w_unused = ^{AWPROT, ARPROT};

    // Keeps every READY low through reset and for the first cycle after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_en <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
        end
    end

    axi_lite_wr_hold #(.W(ADDR_W)) u_aw_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (AWVALID & r_out_en),
        .o_ready   (w_aw_ready),
        .i_data    (AWADDR),
        .i_release (w_commit),
        .o_full    (w_aw_full),
        .o_data    (w_aw_addr)
    );

    axi_lite_wr_hold #(.W(DATA_W + STRB_W)) u_w_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (WVALID & r_out_en),
        .o_ready   (w_w_ready),
        .i_data    ({WSTRB, WDATA}),
        .i_release (w_commit),
        .o_full    (w_w_full),
        .o_data    (w_w_hold)
    );

    assign AWREADY  = w_aw_ready & r_out_en;
    assign WREADY   = w_w_ready & r_out_en;
    assign w_w_data = w_w_hold[DATA_W-1:0];
    assign w_w_strb = w_w_hold[DATA_W +: STRB_W];

    // A write commits once address and data are both held and no response is pending.
    assign w_commit = w_aw_full & w_w_full & ~r_bvalid;

    // Decode the held write address into a one-hot select of writable registers.
    always_comb begin
        w_aw_index = reg_index(64'(w_aw_addr), DATA_W);
        w_wr_sel   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_aw_index == 32'(i) && !RO_MASK[i]) begin
                w_wr_sel[i] = 1'b1;
            end
        end
    end

    // Register array: reset image on reset, strobed byte merge on a committed write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RST_VAL[i*DATA_W +: DATA_W];
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_sel[i]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_w_strb[b]) begin
                            r_regs[i][b*8 +: 8] <= w_w_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Write response and one-cycle pulse, both launched by the commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_bvalid   <= 1'b1;
                r_bresp    <= (|w_wr_sel) ? RESP_OKAY : RESP_SLVERR;
                r_wr_pulse <= w_wr_sel;
            end else if (r_bvalid && BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign BVALID   = r_bvalid;
    assign BRESP    = r_bresp;
    assign wr_pulse = r_wr_pulse;

    // A new read is taken whenever the output slot is empty or draining this cycle.
    assign w_arready = r_out_en & (~r_rvalid | RREADY);
    assign w_ar_hs   = ARVALID & w_arready;
    assign ARREADY   = w_arready;

    // Read mux: stored value for RW, live status for RO, zero/SLVERR when out of range.
    always_comb begin
        w_ar_index = reg_index(64'(ARADDR), DATA_W);
        w_rd_data  = '0;
        w_rd_resp  = RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_index == 32'(i)) begin
                w_rd_resp = RESP_OKAY;
                w_rd_data = RO_MASK[i] ? sts_in[i*DATA_W +: DATA_W] : r_regs[i];
            end
        end
    end

    // Registered read response, held until the master takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign RVALID = r_rvalid;
    assign RDATA  = r_rdata;
    assign RRESP  = r_rresp;

    // Expose the register array; RO slots carry their fixed reset image.
    always_comb begin
        ctrl_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ctrl_out[i*DATA_W +: DATA_W] = r_regs[i];
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Bench for axi_lite_regbank: directed cases pinned to literal values, then
// random traffic checked every cycle against a word/byte-level register model.
module tb_axi_lite_regbank;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 12;
    localparam int          NUM_REGS = 4;
    localparam logic [3:0]  RO_MASK  = 4'b1000;
    localparam logic [127:0] RST_VAL = {32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};

    logic         clk;
    logic         rst_n;
    logic [11:0]  AWADDR;
    logic [2:0]   AWPROT;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic         BVALID;
    logic         BREADY;
    logic [1:0]   BRESP;
    logic [11:0]  ARADDR;
    logic [2:0]   ARPROT;
    logic         ARVALID;
    logic         ARREADY;
    logic         RVALID;
    logic         RREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic [127:0] ctrl_out;
    logic [127:0] sts_in;
    logic [3:0]   wr_pulse;

    axi_lite_regbank #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
        .RO_MASK(RO_MASK), .RST_VAL(RST_VAL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .ctrl_out(ctrl_out), .sts_in(sts_in), .wr_pulse(wr_pulse)
    );

    // ---------------- clock / reset bookkeeping ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b1;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_q = rst_n;
        end
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [1:0]  resp;
        logic [3:0]  pulse;
        int          idx;
        logic [31:0] data;
        logic [3:0]  strb;
    } b_exp_t;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] model_regs [4];
    logic [31:0] rst_img [4];
    logic [3:0]  ro_mask;
    b_exp_t      exp_b_q [$];
    b_exp_t      cur_b;
    logic [31:0] exp_q [$];
    logic [1:0]  exp_rresp_q [$];
    int          exp_rcyc_q [$];
    bit          b_prev    = 0;
    bit          r_started = 0;
    int          b_count   = 0;
    int          r_beats   = 0;
    logic [1:0]  last_bresp;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;
    int          pulse_cnt [4];

    bit          hold_b_low = 0;
    bit          force_r    = 0;
    bit          sts_rand   = 0;
    logic [127:0] sts_fixed = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic b_exp_t predict_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        b_exp_t e;
        int     idx;
        idx    = int'(a) / 4;
        e.idx  = idx;
        e.data = d;
        e.strb = s;
        if (idx < 4 && !ro_mask[idx[1:0]]) begin
            e.resp  = 2'b00;
            e.pulse = 4'(1 << idx);
        end else begin
            e.resp  = 2'b10;
            e.pulse = 4'b0000;
        end
        return e;
    endfunction

    // ---------------- compare process ----------------
    initial begin : compare
        int idx;
        forever begin
            @(negedge clk);
            if (!rst_q) begin
                chk("reset_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, wr_pulse}, 64'd0);
                chk("reset_rdata", RDATA, 64'd0);
                for (int i = 0; i < 4; i++) begin
                    model_regs[i] = rst_img[i];
                    if (!ro_mask[i]) chk("reset_ctrl_out", ctrl_out[i*32 +: 32], rst_img[i]);
                end
                exp_b_q.delete();
                exp_q.delete();
                exp_rresp_q.delete();
                exp_rcyc_q.delete();
                b_prev    = 0;
                r_started = 0;
            end else begin
                // write response and pulse
                if (BVALID && !b_prev) begin
                    if (exp_b_q.size() == 0) begin
                        chk("b_unexpected", BVALID, 64'd0);
                    end else begin
                        cur_b = exp_b_q.pop_front();
                        if (cur_b.resp == 2'b00) begin
                            for (int b = 0; b < 4; b++)
                                if (cur_b.strb[b]) model_regs[cur_b.idx][b*8 +: 8] = cur_b.data[b*8 +: 8];
                        end
                        chk("bresp", BRESP, cur_b.resp);
                        chk("wr_pulse", wr_pulse, cur_b.pulse);
                        last_bresp = BRESP;
                        b_count++;
                    end
                end else begin
                    chk("wr_pulse_idle", wr_pulse, 64'd0);
                    if (BVALID) chk("bresp_hold", BRESP, cur_b.resp);
                end
                b_prev = BVALID && !BREADY;
                for (int i = 0; i < 4; i++) if (wr_pulse[i]) pulse_cnt[i]++;

                for (int i = 0; i < 4; i++)
                    if (!ro_mask[i]) chk("ctrl_out", ctrl_out[i*32 +: 32], model_regs[i]);

                // read data channel
                if (RVALID) begin
                    if (exp_q.size() == 0) begin
                        chk("r_unexpected", RVALID, 64'd0);
                    end else begin
                        if (!r_started) begin
                            chk("r_latency", 64'(cyc - exp_rcyc_q[0]), 64'd1);
                            r_started = 1;
                        end
                        chk("rdata", RDATA, exp_q[0]);
                        chk("rresp", RRESP, exp_rresp_q[0]);
                        if (RREADY) begin
                            last_rdata = RDATA;
                            last_rresp = RRESP;
                            void'(exp_q.pop_front());
                            void'(exp_rresp_q.pop_front());
                            void'(exp_rcyc_q.pop_front());
                            r_started = 0;
                            r_beats++;
                        end
                    end
                end

                // read address handshake at the coming edge: predict its beat
                if (ARVALID && ARREADY) begin
                    idx = int'(ARADDR) / 4;
                    if (idx < 4) begin
                        exp_q.push_back(ro_mask[idx[1:0]] ? sts_in[idx*32 +: 32] : model_regs[idx]);
                        exp_rresp_q.push_back(2'b00);
                    end else begin
                        exp_q.push_back(32'h0);
                        exp_rresp_q.push_back(2'b10);
                    end
                    exp_rcyc_q.push_back(cyc);
                end
            end
        end
    end

    // ---------------- background ready / status drivers ----------------
    initial begin
        BREADY = 1'b0;
        RREADY = 1'b0;
        sts_in = '0;
        forever begin
            @(posedge clk);
            #1;
            BREADY = hold_b_low ? 1'b0 : ($urandom_range(0, 3) != 0);
            RREADY = force_r ? 1'b1 : ($urandom_range(0, 3) != 0);
            sts_in = sts_rand ? {$urandom(), $urandom(), $urandom(), $urandom()} : sts_fixed;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_aw(input logic [11:0] a, input int dly);
        bit hs = 0;
        repeat (dly) begin @(posedge clk); #1; end
        AWADDR  = a;
        AWVALID = 1'b1;
        for (int n = 0; n < 200 && !hs; n++) begin
            @(negedge clk);
            hs = AWREADY;
            @(posedge clk);
            #1;
        end
        AWVALID = 1'b0;
        chk("aw_handshake", 64'(hs), 64'd1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        bit hs = 0;
        repeat (dly) begin @(posedge clk); #1; end
        WDATA  = d;
        WSTRB  = s;
        WVALID = 1'b1;
        for (int n = 0; n < 200 && !hs; n++) begin
            @(negedge clk);
            hs = WREADY;
            @(posedge clk);
            #1;
        end
        WVALID = 1'b0;
        chk("w_handshake", 64'(hs), 64'd1);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        b_exp_t e;
        e = predict_write(a, d, s);
        fork
            send_aw(a, aw_dly);
            send_w(d, s, w_dly);
        join
        exp_b_q.push_back(e);
    endtask

    task automatic do_read(input logic [11:0] a, input int dly);
        bit hs = 0;
        repeat (dly) begin @(posedge clk); #1; end
        ARADDR  = a;
        ARVALID = 1'b1;
        for (int n = 0; n < 200 && !hs; n++) begin
            @(negedge clk);
            hs = ARREADY;
            @(posedge clk);
            #1;
        end
        ARVALID = 1'b0;
        chk("ar_handshake", 64'(hs), 64'd1);
    endtask

    task automatic read_lit(input logic [11:0] a, input logic [31:0] d, input logic [1:0] r,
                            input string nm, input int dly);
        int n0 = r_beats;
        do_read(a, dly);
        for (int n = 0; n < 100 && r_beats == n0; n++) begin @(posedge clk); #1; end
        chk({nm, "_done"}, 64'(r_beats - n0), 64'd1);
        chk({nm, "_data"}, last_rdata, d);
        chk({nm, "_resp"}, last_rresp, r);
    endtask

    task automatic wait_b(input int n0);
        for (int n = 0; n < 200 && b_count == n0; n++) begin @(posedge clk); #1; end
        chk("b_response_seen", 64'(b_count - n0), 64'd1);
    endtask

    task automatic wait_idle();
        bit busy = 1;
        for (int n = 0; n < 300 && busy; n++) begin
            @(posedge clk);
            #1;
            busy = (exp_b_q.size() != 0) || BVALID || (exp_q.size() != 0) || RVALID;
        end
        chk("idle", 64'(busy), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int b0, p0, n0, c0;
        ro_mask = RO_MASK;
        rst_img = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        rst_n = 1'b0;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        ARADDR = '0; ARPROT = '0; ARVALID = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset image of reg1
        read_lit(12'h004, 32'hDEAD_BEEF, 2'b00, "t1_rst_reg1", 0);

        // AW three cycles ahead of W
        b0 = b_count; p0 = pulse_cnt[2];
        do_write(12'h008, 32'h1234_5678, 4'hF, 0, 3);
        wait_b(b0);
        chk("t2_bresp", last_bresp, 2'b00);
        wait_idle();
        chk("t2_pulse_once", 64'(pulse_cnt[2] - p0), 64'd1);
        read_lit(12'h008, 32'h1234_5678, 2'b00, "t2_readback", 0);

        // partial byte strobes
        b0 = b_count;
        do_write(12'h008, 32'hAABB_CCDD, 4'b0101, 0, 0);
        wait_b(b0);
        read_lit(12'h008, 32'h12BB_56DD, 2'b00, "t3_strobe_merge", 0);

        // out-of-range index 4
        b0 = b_count; p0 = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
        do_write(12'h010, 32'h0BAD_F00D, 4'hF, 1, 0);
        wait_b(b0);
        chk("t4_bresp", last_bresp, 2'b10);
        wait_idle();
        chk("t4_no_pulse", 64'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] - p0), 64'd0);
        read_lit(12'h010, 32'h0, 2'b10, "t4_oor_read", 0);

        // read-only register
        sts_fixed[127:96] = 32'hCAFE_0001;
        b0 = b_count;
        do_write(12'h00C, 32'hFFFF_FFFF, 4'hF, 0, 0);
        wait_b(b0);
        chk("t5_ro_bresp", last_bresp, 2'b10);
        read_lit(12'h00C, 32'hCAFE_0001, 2'b00, "t5_ro_read", 0);

        // zero strobes still pulse
        b0 = b_count; p0 = pulse_cnt[0];
        do_write(12'h001, 32'hFFFF_FFFF, 4'h0, 0, 0);
        wait_b(b0);
        chk("t5_zero_strb_bresp", last_bresp, 2'b00);
        wait_idle();
        chk("t5_zero_strb_pulse", 64'(pulse_cnt[0] - p0), 64'd1);
        read_lit(12'h000, 32'h0, 2'b00, "t5_zero_strb_data", 0);

        // read in the commit cycle returns the old value
        b0 = b_count;
        do_write(12'h000, 32'h1111_1111, 4'hF, 0, 0);
        wait_b(b0);
        wait_idle();
        fork
            do_write(12'h000, 32'h2222_2222, 4'hF, 0, 0);
            read_lit(12'h000, 32'h1111_1111, 2'b00, "t5_pre_write_read", 1);
        join
        wait_idle();
        read_lit(12'h000, 32'h2222_2222, 2'b00, "t5_post_write_read", 0);

        // response back-pressure with a second write queued behind it
        wait_idle();
        hold_b_low = 1;
        @(posedge clk); #1;
        b0 = b_count;
        do_write(12'h004, 32'hA5A5_A5A5, 4'hF, 0, 0);
        wait_b(b0);
        do_write(12'h008, 32'h5A5A_5A5A, 4'hF, 1, 2);
        repeat (5) begin @(posedge clk); #1; end
        chk("t6_single_outstanding", 64'(b_count - b0), 64'd1);
        chk("t6_aw_blocked", AWREADY, 64'd0);
        chk("t6_reg2_not_committed", ctrl_out[64 +: 32], 32'h12BB_56DD);
        hold_b_low = 0;
        wait_b(b0 + 1);
        chk("t6_second_bresp", last_bresp, 2'b00);
        wait_idle();
        read_lit(12'h008, 32'h5A5A_5A5A, 2'b00, "t6_second_data", 0);

        // back-to-back reads, one per cycle
        force_r = 1;
        @(posedge clk); #1;
        n0 = r_beats; c0 = cyc;
        for (int i = 0; i < 4; i++) do_read(12'(i * 4), 0);
        chk("t6_b2b_ar_cycles", 64'(cyc - c0), 64'd4);
        @(posedge clk); #1;
        chk("t6_b2b_beats", 64'(r_beats - n0), 64'd4);
        force_r = 0;
        wait_idle();

        // reset with an address accepted but no data yet
        b0 = b_count;
        send_aw(12'h004, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("t6_no_b_after_reset", 64'(b_count - b0), 64'd0);
        read_lit(12'h004, 32'hDEAD_BEEF, 2'b00, "t6_reset_reload", 0);
        b0 = b_count;
        do_write(12'h004, 32'h0102_0304, 4'hF, 0, 0);
        wait_b(b0);
        read_lit(12'h004, 32'h0102_0304, 2'b00, "t6_after_reset_write", 0);

        // randomized traffic against the model
        sts_rand = 1;
        for (int t = 0; t < 200; t++) begin
            logic [11:0] a;
            a = 12'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0)
                do_write(a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 2));
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
